// File: rtl/patch_stream_serializer.sv
// Snapshots the patchifier's patch array when it reports DONE, then streams it
// out one pixel per beat over valid/ready with patch-boundary flags.
module patch_stream_serializer #(
  parameter int PIXEL_WIDTH       = 24,
  parameter int TOTAL_NUM_PATCHES = 16,
  parameter int PATCH_VECTOR_SIZE = 16,
  parameter int PATCH_IDX_W       = $clog2(TOTAL_NUM_PATCHES),
  parameter int POS_IDX_W         = $clog2(PATCH_VECTOR_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             patch_state,
  input  logic [PIXEL_WIDTH-1:0] all_patches [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE],
  output logic                   output_taken,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIXEL_WIDTH-1:0] m_data,
  output logic [PATCH_IDX_W-1:0] m_patch_idx,
  output logic [POS_IDX_W-1:0]   m_pos_idx,
  output logic                   m_sop,
  output logic                   m_eop,
  output logic                   m_last,
  output logic                   busy
);

  localparam logic [2:0]             PATCH_DONE = 3'b100;
  localparam logic [PATCH_IDX_W-1:0] PATCH_LAST = PATCH_IDX_W'(TOTAL_NUM_PATCHES - 1);
  localparam logic [POS_IDX_W-1:0]   POS_LAST   = POS_IDX_W'(PATCH_VECTOR_SIZE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state_q, state_d;
  logic [PATCH_IDX_W-1:0] patch_q, patch_d;
  logic [POS_IDX_W-1:0]   pos_q, pos_d;
  logic                   output_taken_q, output_taken_d;
  logic                   capture;
  logic                   last_beat;

  // Snapshot storage; loaded in a single cycle, so it lives in fabric registers.
  logic [PIXEL_WIDTH-1:0] buf_q [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE];

  assign last_beat = (patch_q == PATCH_LAST) && (pos_q == POS_LAST);

  always_comb begin
    state_d        = state_q;
    patch_d        = patch_q;
    pos_d          = pos_q;
    output_taken_d = 1'b0;
    capture        = 1'b0;
    case (state_q)
      IDLE: begin
        if (patch_state == PATCH_DONE) begin
          capture        = 1'b1;
          output_taken_d = 1'b1;
          patch_d        = '0;
          pos_d          = '0;
          state_d        = STREAM;
        end
      end
      STREAM: begin
        if (m_ready) begin
          if (last_beat) begin
            patch_d = '0;
            pos_d   = '0;
            state_d = IDLE;
          end else if (pos_q == POS_LAST) begin
            pos_d   = '0;
            patch_d = patch_q + PATCH_IDX_W'(1);
          end else begin
            pos_d = pos_q + POS_IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      patch_q        <= '0;
      pos_q          <= '0;
      output_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      patch_q        <= patch_d;
      pos_q          <= pos_d;
      output_taken_q <= output_taken_d;
    end
  end

  // The snapshot is deliberately not cleared by reset.
  for (genvar gi = 0; gi < TOTAL_NUM_PATCHES; gi++) begin : g_buf_row
    always_ff @(posedge clk) begin
      if (capture && !reset) begin
        buf_q[gi] <= all_patches[gi];
      end
    end
  end

  assign output_taken = output_taken_q;
  assign m_valid      = (state_q == STREAM);
  assign busy         = (state_q != IDLE);
  assign m_data       = buf_q[patch_q][pos_q];
  assign m_patch_idx  = patch_q;
  assign m_pos_idx    = pos_q;
  assign m_sop        = (pos_q == '0);
  assign m_eop        = (pos_q == POS_LAST);
  assign m_last       = last_beat;

endmodule

// File: tb/tb_patch_stream_serializer.sv
// Scoreboard bench: the driver pushes each image's expected beat sequence,
// and a monitor pops and compares on every accepted beat.
module tb_patch_stream_serializer;

  localparam int NP    = 16;
  localparam int NV    = 16;
  localparam int BEATS = NP * NV;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  patch_state;
  logic [23:0] img_in [NP][NV];
  logic        output_taken, m_valid, m_ready, m_sop, m_eop, m_last, busy;
  logic [23:0] m_data;
  logic [3:0]  m_patch_idx, m_pos_idx;

  patch_stream_serializer dut (
    .clk(clk), .reset(reset), .patch_state(patch_state), .all_patches(img_in),
    .output_taken(output_taken), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_patch_idx(m_patch_idx), .m_pos_idx(m_pos_idx),
    .m_sop(m_sop), .m_eop(m_eop), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [34:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int ot_count = 0;
  int ot_expected = 0;
  int rdy_mode = 0;
  int stall_left = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: beat k of an image is pixel (k/NV, k%NV) with flags from k alone.
  task automatic push_image();
    for (int k = 0; k < BEATS; k++) begin
      logic [34:0] e;
      e = {img_in[k / NV][k % NV], 4'(k / NV), 4'(k % NV),
           (k % NV) == 0, (k % NV) == NV - 1, k == BEATS - 1};
      exp_q.push_back(e);
    end
  endtask

  task automatic step_neg();
    @(negedge clk);
    #1;
  endtask

  // Ready driver: 0 = always ready, 1 = 5-cycle stall while beat 17 is shown, 2 = random.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          if (exp_q.size() == BEATS - 17 && stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
          end else begin
            m_ready = 1'b1;
          end
        end
        2:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor
  initial begin
    forever begin
      logic [34:0] act;
      logic [34:0] e;
      @(negedge clk);
      if (output_taken === 1'b1) ot_count++;
      if (m_valid === 1'b1) begin
        act = {m_data, m_patch_idx, m_pos_idx, m_sop, m_eop, m_last};
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", 64'(act), 64'(0));
        end else if (m_ready) begin
          e = exp_q.pop_front();
          check(act === e, "beat", 64'(act), 64'(e));
        end else begin
          check(act === exp_q[0], "hold_stable", 64'(act), 64'(exp_q[0]));
        end
      end
    end
  end

  task automatic start_image(input bit hold);
    @(posedge clk);
    #1;
    push_image();
    patch_state = 3'b100;
    step_neg();
    check(output_taken === 1'b0, "ot_before_capture", 64'(output_taken), 64'(0));
    @(posedge clk);
    step_neg();
    check(output_taken === 1'b1 && m_valid === 1'b1, "ot_and_valid_after_capture",
          64'({output_taken, m_valid}), 64'(2'b11));
    ot_expected++;
    @(posedge clk);
    #1;
    if (!hold) patch_state = 3'b000;
    step_neg();
    check(output_taken === 1'b0, "ot_single_cycle", 64'(output_taken), 64'(0));
  endtask

  task automatic wait_idle(input bit contiguous);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 3000) begin
      step_neg();
      cnt++;
    end
    check(exp_q.size() == 0, "stream_timeout", 64'(exp_q.size()), 64'(0));
    if (contiguous) check(cnt + 2 == BEATS, "contiguous_beats", 64'(cnt + 2), 64'(BEATS));
    step_neg();
    check(m_valid === 1'b0 && busy === 1'b0 && m_sop === 1'b1 && m_last === 1'b0,
          "idle_after_last", 64'({m_valid, busy, m_sop, m_last}), 64'(4'b0010));
  endtask

  task automatic fill_ramp();
    for (int p = 0; p < NP; p++)
      for (int q = 0; q < NV; q++) img_in[p][q] = 24'(p * NV + q);
  endtask

  task automatic fill_random();
    for (int p = 0; p < NP; p++)
      for (int q = 0; q < NV; q++) img_in[p][q] = 24'($urandom);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    patch_state = 3'b000;
    fill_ramp();

    // Reset state
    repeat (3) @(posedge clk);
    step_neg();
    check(m_valid === 1'b0, "reset_m_valid", 64'(m_valid), 64'(0));
    check(output_taken === 1'b0, "reset_output_taken", 64'(output_taken), 64'(0));
    check(busy === 1'b0, "reset_busy", 64'(busy), 64'(0));
    check(m_patch_idx === 4'd0 && m_pos_idx === 4'd0, "reset_counters",
          64'({m_patch_idx, m_pos_idx}), 64'(0));
    check(m_sop === 1'b1 && m_eop === 1'b0 && m_last === 1'b0, "reset_flags",
          64'({m_sop, m_eop, m_last}), 64'(3'b100));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ramp image, always ready
    rdy_mode = 0;
    start_image(1'b0);
    wait_idle(1'b1);

    // Backpressure at beat 17, plus overwrite of the source after capture
    rdy_mode = 1;
    stall_left = 5;
    start_image(1'b0);
    for (int p = 0; p < NP; p++)
      for (int q = 0; q < NV; q++) img_in[p][q] = 24'hFFFFFF;
    wait_idle(1'b0);
    check(stall_left == 0, "stall_applied", 64'(stall_left), 64'(0));

    // Reset at beat 100, then restart from beat 0
    rdy_mode = 0;
    fill_ramp();
    start_image(1'b0);
    cnt = 0;
    while (exp_q.size() > BEATS - 101 && cnt < 3000) begin
      step_neg();
      cnt++;
    end
    check(exp_q.size() == BEATS - 101, "reach_beat_100", 64'(exp_q.size()), 64'(BEATS - 101));
    reset = 1'b1;
    exp_q.delete();
    step_neg();
    check(m_valid === 1'b0 && busy === 1'b0, "reset_midstream",
          64'({m_valid, busy}), 64'(0));
    check(m_patch_idx === 4'd0 && m_pos_idx === 4'd0, "reset_midstream_counters",
          64'({m_patch_idx, m_pos_idx}), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_mode = 2;
    fill_random();
    start_image(1'b0);
    wait_idle(1'b0);

    // Back-to-back: DONE held through the stream, recaptured on first IDLE cycle
    fill_random();
    start_image(1'b1);
    fill_random();
    push_image();
    cnt = 0;
    while (exp_q.size() > BEATS && cnt < 3000) begin
      step_neg();
      cnt++;
    end
    check(exp_q.size() == BEATS, "first_image_done", 64'(exp_q.size()), 64'(BEATS));
    step_neg();
    check(m_valid === 1'b0 && output_taken === 1'b0, "gap_idle_cycle",
          64'({m_valid, output_taken}), 64'(0));
    step_neg();
    check(output_taken === 1'b1 && m_valid === 1'b1, "second_capture",
          64'({output_taken, m_valid}), 64'(2'b11));
    ot_expected++;
    @(posedge clk);
    #1;
    patch_state = 3'b000;
    wait_idle(1'b0);

    // Random images under random backpressure
    for (int n = 0; n < 2; n++) begin
      fill_random();
      start_image(1'b0);
      wait_idle(1'b0);
    end

    check(ot_count == ot_expected, "output_taken_count", 64'(ot_count), 64'(ot_expected));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
